// File: rtl/id_operand_stage.sv
// rtl/id_operand_stage.sv - decode-stage operand path: register file, bypass, forwarding, stall, ID/EX register
// Operands resolve combinationally in ID; the ID/EX register inserts bubbles on flush, stall or idle.
module id_operand_stage #(
   parameter int WIDTH     = 32,
   parameter int AW        = 5,
   parameter int NREAD     = 2,
   parameter int NFWD      = 2,
   parameter int TW        = 3,
   parameter int PAYLOAD_W = 64,
   parameter int ZERO_REG  = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic [NREAD*AW-1:0]    in_raddr,
   input  logic [NREAD*TW-1:0]    in_tuse,
   input  logic [AW-1:0]          in_waddr,
   input  logic [TW-1:0]          in_tnew,
   input  logic [PAYLOAD_W-1:0]   in_payload,
   input  logic [WIDTH-1:0]       in_pc,
   input  logic                   wb_we,
   input  logic [AW-1:0]          wb_addr,
   input  logic [WIDTH-1:0]       wb_data,
   input  logic [NFWD-1:0]        fwd_valid,
   input  logic [NFWD*AW-1:0]     fwd_addr,
   input  logic [NFWD*TW-1:0]     fwd_tnew,
   input  logic [NFWD*WIDTH-1:0]  fwd_data,
   input  logic                   flush,
   output logic [NREAD*WIDTH-1:0] id_rdata,
   output logic                   stall,
   output logic                   ex_valid,
   output logic [NREAD*AW-1:0]    ex_raddr,
   output logic [NREAD*WIDTH-1:0] ex_rdata,
   output logic [NREAD*TW-1:0]    ex_tuse,
   output logic [AW-1:0]          ex_waddr,
   output logic [TW-1:0]          ex_tnew,
   output logic [PAYLOAD_W-1:0]   ex_payload,
   output logic [WIDTH-1:0]       ex_pc
);
   localparam int DEPTH = 2**AW;

   logic [WIDTH-1:0]       rf_q [DEPTH];
   logic [NREAD*WIDTH-1:0] rdata;
   logic [NREAD-1:0]       pend;
   logic [NREAD-1:0]       hazard;
   logic [TW-1:0]          own_tnew [NREAD];
   logic                   wb_write;

   logic                   ex_valid_q,   ex_valid_d;
   logic [NREAD*AW-1:0]    ex_raddr_q,   ex_raddr_d;
   logic [NREAD*WIDTH-1:0] ex_rdata_q,   ex_rdata_d;
   logic [NREAD*TW-1:0]    ex_tuse_q,    ex_tuse_d;
   logic [AW-1:0]          ex_waddr_q,   ex_waddr_d;
   logic [TW-1:0]          ex_tnew_q,    ex_tnew_d;
   logic [PAYLOAD_W-1:0]   ex_payload_q, ex_payload_d;
   logic [WIDTH-1:0]       ex_pc_q,      ex_pc_d;

   assign wb_write = wb_we && !(ZERO_REG != 0 && wb_addr == '0);

   // Sources are scanned far-to-near so the nearest matching stage overwrites and owns the operand.
   always_comb begin
      rdata  = '0;
      pend   = '0;
      hazard = '0;
      for (int i = 0; i < NREAD; i++) begin
         own_tnew[i] = '0;
         if (wb_we && wb_addr == in_raddr[i*AW +: AW])
            rdata[i*WIDTH +: WIDTH] = wb_data;
         else
            rdata[i*WIDTH +: WIDTH] = rf_q[in_raddr[i*AW +: AW]];
         for (int j = NFWD-1; j >= 0; j--) begin
            if (fwd_valid[j] && fwd_addr[j*AW +: AW] == in_raddr[i*AW +: AW] &&
                fwd_addr[j*AW +: AW] != '0) begin
               own_tnew[i] = fwd_tnew[j*TW +: TW];
               pend[i]     = (fwd_tnew[j*TW +: TW] != '0);
               if (fwd_tnew[j*TW +: TW] == '0)
                  rdata[i*WIDTH +: WIDTH] = fwd_data[j*WIDTH +: WIDTH];
            end
         end
         if (ZERO_REG != 0 && in_raddr[i*AW +: AW] == '0) begin
            rdata[i*WIDTH +: WIDTH] = '0;
            pend[i]                 = 1'b0;
         end
         hazard[i] = pend[i] && (in_tuse[i*TW +: TW] != '1) &&
                     (own_tnew[i] > in_tuse[i*TW +: TW]);
      end
   end

   assign id_rdata = rdata;
   assign stall    = in_valid && (|hazard);

   always_comb begin
      ex_valid_d   = 1'b0;
      ex_raddr_d   = '0;
      ex_rdata_d   = '0;
      ex_tuse_d    = '1;
      ex_waddr_d   = '0;
      ex_tnew_d    = '0;
      ex_payload_d = '0;
      ex_pc_d      = '0;
      if (!flush && !stall && in_valid) begin
         ex_valid_d   = 1'b1;
         ex_raddr_d   = in_raddr;
         ex_rdata_d   = rdata;
         ex_tuse_d    = in_tuse;
         ex_waddr_d   = in_waddr;
         ex_tnew_d    = in_tnew;
         ex_payload_d = in_payload;
         ex_pc_d      = in_pc;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < DEPTH; k++) rf_q[k] <= '0;
         ex_valid_q   <= 1'b0;
         ex_raddr_q   <= '0;
         ex_rdata_q   <= '0;
         ex_tuse_q    <= '1;
         ex_waddr_q   <= '0;
         ex_tnew_q    <= '0;
         ex_payload_q <= '0;
         ex_pc_q      <= '0;
      end else begin
         if (wb_write) rf_q[wb_addr] <= wb_data;
         ex_valid_q   <= ex_valid_d;
         ex_raddr_q   <= ex_raddr_d;
         ex_rdata_q   <= ex_rdata_d;
         ex_tuse_q    <= ex_tuse_d;
         ex_waddr_q   <= ex_waddr_d;
         ex_tnew_q    <= ex_tnew_d;
         ex_payload_q <= ex_payload_d;
         ex_pc_q      <= ex_pc_d;
      end
   end

   assign ex_valid   = ex_valid_q;
   assign ex_raddr   = ex_raddr_q;
   assign ex_rdata   = ex_rdata_q;
   assign ex_tuse    = ex_tuse_q;
   assign ex_waddr   = ex_waddr_q;
   assign ex_tnew    = ex_tnew_q;
   assign ex_payload = ex_payload_q;
   assign ex_pc      = ex_pc_q;
endmodule

// File: tb/tb_id_operand_stage.sv
// tb/tb_id_operand_stage.sv - directed self-checking bench for id_operand_stage
module tb_id_operand_stage;
   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [9:0]  in_raddr;
   logic [5:0]  in_tuse;
   logic [4:0]  in_waddr;
   logic [2:0]  in_tnew;
   logic [63:0] in_payload;
   logic [31:0] in_pc;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic [1:0]  fwd_valid;
   logic [9:0]  fwd_addr;
   logic [5:0]  fwd_tnew;
   logic [63:0] fwd_data;
   logic        flush;
   logic [63:0] id_rdata;
   logic        stall;
   logic        ex_valid;
   logic [9:0]  ex_raddr;
   logic [63:0] ex_rdata;
   logic [5:0]  ex_tuse;
   logic [4:0]  ex_waddr;
   logic [2:0]  ex_tnew;
   logic [63:0] ex_payload;
   logic [31:0] ex_pc;

   int vectors = 0;
   int miscompares = 0;

   id_operand_stage dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_raddr(in_raddr),
      .in_tuse(in_tuse), .in_waddr(in_waddr), .in_tnew(in_tnew),
      .in_payload(in_payload), .in_pc(in_pc), .wb_we(wb_we), .wb_addr(wb_addr),
      .wb_data(wb_data), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
      .fwd_tnew(fwd_tnew), .fwd_data(fwd_data), .flush(flush),
      .id_rdata(id_rdata), .stall(stall), .ex_valid(ex_valid), .ex_raddr(ex_raddr),
      .ex_rdata(ex_rdata), .ex_tuse(ex_tuse), .ex_waddr(ex_waddr), .ex_tnew(ex_tnew),
      .ex_payload(ex_payload), .ex_pc(ex_pc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      in_valid = 0; in_raddr = '0; in_tuse = '0; in_waddr = '0; in_tnew = '0;
      in_payload = '0; in_pc = '0; wb_we = 0; wb_addr = '0; wb_data = '0;
      fwd_valid = '0; fwd_addr = '0; fwd_tnew = '0; fwd_data = '0; flush = 0;
   endtask

   task automatic edge_then_sample();
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b0;
      idle();
      #12;
      check("reset_ex_valid", {63'd0, ex_valid}, 64'd0);
      check("reset_ex_tuse", {58'd0, ex_tuse}, 64'h3F);
      @(negedge clk); reset = 1'b1;

      // read r5 (port0) and r0 (port1) after reset
      in_raddr = {5'd0, 5'd5}; #1;
      check("rst_read_r5_r0", id_rdata, 64'd0);
      edge_then_sample();
      check("idle_ex_valid", {63'd0, ex_valid}, 64'd0);
      check("idle_ex_tuse", {58'd0, ex_tuse}, 64'h3F);

      // write-first bypass into a captured instruction
      @(negedge clk);
      wb_we = 1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
      in_valid = 1; in_raddr = {5'd0, 5'd5}; in_waddr = 5'd3; in_tnew = 3'd1;
      in_tuse = 6'b000_001; in_payload = 64'h0123_4567_89AB_CDEF; in_pc = 32'h0000_1000;
      #1;
      check("bypass_id_rdata", id_rdata, 64'h0000_0000_DEAD_BEEF);
      edge_then_sample();
      check("bypass_ex_rdata", ex_rdata, 64'h0000_0000_DEAD_BEEF);
      check("capture_ex_valid", {63'd0, ex_valid}, 64'd1);
      check("capture_ex_waddr", {59'd0, ex_waddr}, 64'd3);
      check("capture_ex_payload", ex_payload, 64'h0123_4567_89AB_CDEF);
      check("capture_ex_pc", {32'd0, ex_pc}, 64'h1000);
      check("capture_ex_raddr", {54'd0, ex_raddr}, 64'd5);
      @(negedge clk); wb_we = 0; in_valid = 0; #1;
      check("array_r5", id_rdata, 64'h0000_0000_DEAD_BEEF);

      // forwarding priority
      fwd_valid = 2'b11; fwd_addr = {5'd8, 5'd8}; fwd_tnew = '0;
      fwd_data = {32'h22, 32'h11}; in_raddr = {5'd5, 5'd8}; #1;
      check("fwd_nearest_wins", id_rdata, {32'hDEAD_BEEF, 32'h11});
      fwd_valid = 2'b10; #1;
      check("fwd_far_only", id_rdata[31:0], 64'h22);
      fwd_valid = 2'b11; fwd_tnew = {3'd0, 3'd1}; in_valid = 1; in_tuse = 6'b111_000; #1;
      check("no_fallthrough_stall", {63'd0, stall}, 64'd1);

      // Tuse/Tnew stall
      fwd_valid = 2'b01; fwd_addr = {5'd0, 5'd9}; fwd_tnew = {3'd0, 3'd2};
      in_raddr = {5'd0, 5'd9}; in_tuse = 6'b000_001; in_waddr = 5'd4; #1;
      check("stall_tuse1", {63'd0, stall}, 64'd1);
      edge_then_sample();
      check("stall_bubble_valid", {63'd0, ex_valid}, 64'd0);
      check("stall_bubble_waddr", {59'd0, ex_waddr}, 64'd0);
      @(negedge clk); in_tuse = 6'b000_010; #1;
      check("nostall_tuse2", {63'd0, stall}, 64'd0);
      in_tuse = 6'b000_111; #1;
      check("nostall_unused", {63'd0, stall}, 64'd0);
      in_tuse = 6'b000_001; in_valid = 0; #1;
      check("nostall_invalid", {63'd0, stall}, 64'd0);

      // flush with stall, plus a write to r0
      in_valid = 1; flush = 1; wb_we = 1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF; #1;
      check("flush_stall_reported", {63'd0, stall}, 64'd1);
      edge_then_sample();
      check("flush_ex_valid", {63'd0, ex_valid}, 64'd0);
      check("flush_ex_waddr", {59'd0, ex_waddr}, 64'd0);
      @(negedge clk); idle(); in_raddr = {5'd5, 5'd0}; #1;
      check("r0_reads_zero", id_rdata, {32'hDEAD_BEEF, 32'h0});

      // asynchronous reset mid-stream
      in_valid = 1; in_waddr = 5'd7; in_pc = 32'h2000;
      edge_then_sample();
      check("pre_reset_ex_valid", {63'd0, ex_valid}, 64'd1);
      #2 reset = 1'b0; #1;
      check("async_reset_ex_valid", {63'd0, ex_valid}, 64'd0);
      check("async_reset_ex_rdata", ex_rdata, 64'd0);
      check("async_reset_ex_pc", {32'd0, ex_pc}, 64'd0);
      @(negedge clk); reset = 1'b1; in_valid = 0; #1;
      check("post_reset_r5", id_rdata, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
